edgcol_dispatch: RTL and testbench

Parametrised successor to the single-honeybee Xedgcol datapath. It holds the six edge operand registers and accepts collision-check commands from the main controller. Each command is dispatched round-robin to one of NUM_HB honeybee accelerator instances, and the 64-bit collision results are returned strictly in issue order through a RES_DEPTH-entry result buffer. The core pops each result as a low word (EX path) and a high word (MEM path); this decouples the core from accelerator latency, which a single start/done pair cannot do.

---
 rtl/edgcol_pkg.sv | 22 ++
 rtl/edgcol_unit_ctrl.sv | 89 ++++++++
 rtl/edgcol_dispatch.sv | 235 +++++++++++++++++++++++
 tb/tb_edgcol_dispatch.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edgcol_pkg.sv
// Shared definitions for the edge-collision dispatch slice.
// Holds the operand count, the result width, the edge register indices
// (point 1 xyz, point 2 xyz) and the per-unit state encoding.
package edgcol_pkg;

  localparam int EDGE_COUNT   = 6;
  localparam int RESULT_WIDTH = 64;

  localparam int E_P1_X = 0;
  localparam int E_P1_Y = 1;
  localparam int E_P1_Z = 2;
  localparam int E_P2_X = 3;
  localparam int E_P2_Y = 4;
  localparam int E_P2_Z = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } unit_state_e;

endpackage

// File: rtl/edgcol_unit_ctrl.sv
// Control for one honeybee accelerator instance.
// Latches the operand snapshot on dispatch, holds ap_start while the
// accelerator runs, captures ap_return on ap_done and then waits in DONE
// until the top level retires the result into the result buffer.
//
// Ports:
//   clk, rstb     clock and synchronous active-low reset
//   dispatch_i    start a new job with edges_i (only honoured in IDLE)
//   edges_i       packed e0..e5, e0 in the low bits
//   retire_i      result has been pushed; return to IDLE (DONE only)
//   hb_done_i     ap_done pulse from the accelerator
//   hb_result_i   ap_return, valid with hb_done_i
//   hb_start_o    ap_start, high throughout RUN
//   hb_edge_o     operand snapshot presented to the accelerator
//   idle_o        unit can accept a new job
//   done_o        unit holds a result waiting to retire
//   result_o      captured result
module edgcol_unit_ctrl
  import edgcol_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rstb,
  input  logic                              dispatch_i,
  input  logic [EDGE_COUNT*BUS_WIDTH-1:0]   edges_i,
  input  logic                              retire_i,
  input  logic                              hb_done_i,
  input  logic [RESULT_WIDTH-1:0]           hb_result_i,
  output logic                              hb_start_o,
  output logic [EDGE_COUNT*BUS_WIDTH-1:0]   hb_edge_o,
  output logic                              idle_o,
  output logic                              done_o,
  output logic [RESULT_WIDTH-1:0]           result_o
);

  localparam int SNAP_W = EDGE_COUNT * BUS_WIDTH;

  unit_state_e             state_q, state_d;
  logic [SNAP_W-1:0]       snap_q, snap_d;
  logic [RESULT_WIDTH-1:0] result_q, result_d;

  // State, snapshot and result registers.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q  <= IDLE;
      snap_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      result_q <= result_d;
    end
  end

  // Next-state logic. ap_done outside RUN is a stale pulse and is ignored.
  always_comb begin
    state_d  = state_q;
    snap_d   = snap_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (dispatch_i) begin
          state_d = RUN;
          snap_d  = edges_i;
        end
      end
      RUN: begin
        if (hb_done_i) begin
          state_d  = DONE;
          result_d = hb_result_i;
        end
      end
      DONE: begin
        if (retire_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign hb_start_o = (state_q == RUN);
  assign hb_edge_o  = snap_q;
  assign idle_o     = (state_q == IDLE);
  assign done_o     = (state_q == DONE);
  assign result_o   = result_q;

endmodule

// File: rtl/edgcol_dispatch.sv
// Edge-collision command dispatcher.
// Holds the six edge operand registers, hands each collision command to
// the next honeybee unit in round-robin order and returns the 64-bit
// results strictly in issue order through a small result FIFO whose head
// is presented as registered low/high halves.
//
// Ports:
//   clk, rstb                  clock and synchronous active-low reset
//   edge_wr_ena/addr/imm       load edge register addr with {imm, 6'b0}
//   cmd_valid / cmd_ready      collision command handshake
//   hb_start, hb_done          per-unit ap_start / ap_done
//   hb_result                  per-unit ap_return (64 bits each)
//   hb_edge                    per-unit operand snapshot, e0 lowest
//   res_valid / res_ready      result pop handshake
//   res_lo, res_hi             head result bits [31:0] and [63:32]
//   res_count                  result buffer occupancy
//   busy                       any unit active or results pending
module edgcol_dispatch
  import edgcol_pkg::*;
#(
  parameter int BUS_WIDTH = 32,
  parameter int NUM_HB    = 2,
  parameter int RES_DEPTH = 4,
  parameter int IMM_WIDTH = 26
) (
  input  logic                                  clk,
  input  logic                                  rstb,
  input  logic                                  edge_wr_ena,
  input  logic [2:0]                            edge_wr_addr,
  input  logic [IMM_WIDTH-1:0]                  edge_wr_imm,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  output logic [NUM_HB-1:0]                     hb_start,
  input  logic [NUM_HB-1:0]                     hb_done,
  input  logic [NUM_HB*64-1:0]                  hb_result,
  output logic [NUM_HB*6*BUS_WIDTH-1:0]         hb_edge,
  output logic                                  res_valid,
  input  logic                                  res_ready,
  output logic [BUS_WIDTH-1:0]                  res_lo,
  output logic [BUS_WIDTH-1:0]                  res_hi,
  output logic [$clog2(RES_DEPTH+1)-1:0]        res_count,
  output logic                                  busy
);

  localparam int IDX_W  = (NUM_HB > 1) ? $clog2(NUM_HB) : 1;
  localparam int PTR_W  = $clog2(RES_DEPTH);
  localparam int CNT_W  = $clog2(RES_DEPTH + 1);
  localparam int SNAP_W = EDGE_COUNT * BUS_WIDTH;
  localparam int HALF_W = RESULT_WIDTH / 2;

  // ---------------------------------------------------------------------
  // Edge operand registers
  // ---------------------------------------------------------------------
  logic [BUS_WIDTH-1:0]    edge_q [EDGE_COUNT];
  logic [BUS_WIDTH-1:0]    edge_d [EDGE_COUNT];
  logic [IMM_WIDTH+5:0]    imm_shifted;
  logic [BUS_WIDTH-1:0]    edge_wr_val;
  logic [SNAP_W-1:0]       edges_flat;

  assign imm_shifted = {edge_wr_imm, 6'b0};
  assign edge_wr_val = BUS_WIDTH'(imm_shifted);

  // Indices 6 and 7 have no backing register and are dropped.
  always_comb begin
    edge_d = edge_q;
    if (edge_wr_ena && (edge_wr_addr < 3'd6)) begin
      edge_d[edge_wr_addr] = edge_wr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      for (int e = 0; e < EDGE_COUNT; e++) begin
        edge_q[e] <= '0;
      end
    end else begin
      edge_q <= edge_d;
    end
  end

  // The snapshot is taken from the registered values, so a write in the
  // same cycle as an accept only affects later commands.
  always_comb begin
    edges_flat = '0;
    for (int e = 0; e < EDGE_COUNT; e++) begin
      edges_flat[e*BUS_WIDTH +: BUS_WIDTH] = edge_q[e];
    end
  end

  // ---------------------------------------------------------------------
  // Honeybee unit controllers
  // ---------------------------------------------------------------------
  logic [NUM_HB-1:0]       unit_idle;
  logic [NUM_HB-1:0]       unit_done;
  logic [NUM_HB-1:0]       unit_dispatch;
  logic [NUM_HB-1:0]       unit_retire;
  logic [RESULT_WIDTH-1:0] unit_result [NUM_HB];

  logic [IDX_W-1:0]        ip_q, ip_d;
  logic [IDX_W-1:0]        rp_q, rp_d;
  logic                    cmd_accept;
  logic                    retire;

  for (genvar g = 0; g < NUM_HB; g++) begin : g_unit
    assign unit_dispatch[g] = cmd_accept && (ip_q == IDX_W'(g));
    assign unit_retire[g]   = retire && (rp_q == IDX_W'(g));

    edgcol_unit_ctrl #(
      .BUS_WIDTH (BUS_WIDTH)
    ) u_unit (
      .clk         (clk),
      .rstb        (rstb),
      .dispatch_i  (unit_dispatch[g]),
      .edges_i     (edges_flat),
      .retire_i    (unit_retire[g]),
      .hb_done_i   (hb_done[g]),
      .hb_result_i (hb_result[g*RESULT_WIDTH +: RESULT_WIDTH]),
      .hb_start_o  (hb_start[g]),
      .hb_edge_o   (hb_edge[g*SNAP_W +: SNAP_W]),
      .idle_o      (unit_idle[g]),
      .done_o      (unit_done[g]),
      .result_o    (unit_result[g])
    );
  end

  // ---------------------------------------------------------------------
  // Issue / retire pointers
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    buf_full;
  logic                    push;
  logic                    pop;
  logic [RESULT_WIDTH-1:0] push_data;

  assign cmd_ready  = unit_idle[ip_q];
  assign cmd_accept = cmd_valid && cmd_ready;

  assign buf_full   = (count_q == CNT_W'(RES_DEPTH));
  assign pop        = res_ready && (count_q != '0);
  // Retiring into a full buffer is allowed only when the head leaves in
  // the same cycle, so nothing is ever overwritten.
  assign retire     = unit_done[rp_q] && (!buf_full || pop);
  assign push       = retire;
  assign push_data  = unit_result[rp_q];

  // Pointers wrap at NUM_HB, which need not be a power of two.
  always_comb begin
    ip_d = ip_q;
    rp_d = rp_q;
    if (cmd_accept) begin
      ip_d = (ip_q == IDX_W'(NUM_HB - 1)) ? '0 : ip_q + IDX_W'(1);
    end
    if (retire) begin
      rp_d = (rp_q == IDX_W'(NUM_HB - 1)) ? '0 : rp_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      ip_q <= '0;
      rp_q <= '0;
    end else begin
      ip_q <= ip_d;
      rp_q <= rp_d;
    end
  end

  // ---------------------------------------------------------------------
  // Result FIFO with registered head
  // ---------------------------------------------------------------------
  logic [RESULT_WIDTH-1:0] mem_q [RES_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        rd_next;
  logic [RESULT_WIDTH-1:0] head_q, head_d;

  assign rd_next = rd_ptr_q + PTR_W'(1);

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // The head register mirrors mem_q[rd_ptr]. When only one entry remains
  // and it is popped, the next head is whatever is being pushed now.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_next;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (push && (count_q == '0)) begin
      head_d = push_data;
    end else if (pop) begin
      if (count_q == CNT_W'(1)) begin
        head_d = push ? push_data : '0;
      end else begin
        head_d = mem_q[rd_next];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign res_valid = (count_q != '0);
  assign res_count = count_q;
  assign res_lo    = BUS_WIDTH'(head_q[HALF_W-1:0]);
  assign res_hi    = BUS_WIDTH'(head_q[RESULT_WIDTH-1:HALF_W]);
  assign busy      = (~unit_idle != '0) || (count_q != '0);

endmodule

// File: tb/tb_edgcol_dispatch.sv
// Directed bench for edgcol_dispatch with a result scoreboard.
// Each accepted command pushes its planned result; a negedge monitor pops
// and compares whenever the DUT pops a result.
module tb_edgcol_dispatch;

  localparam int BW    = 32;
  localparam int NHB   = 2;
  localparam int DEPTH = 4;
  localparam int IMMW  = 26;
  localparam int SNAPW = 6 * BW;

  logic                     clk;
  logic                     rstb;
  logic                     edge_wr_ena;
  logic [2:0]               edge_wr_addr;
  logic [IMMW-1:0]          edge_wr_imm;
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [NHB-1:0]           hb_start;
  logic [NHB-1:0]           hb_done;
  logic [NHB*64-1:0]        hb_result;
  logic [NHB*SNAPW-1:0]     hb_edge;
  logic                     res_valid;
  logic                     res_ready;
  logic [BW-1:0]            res_lo;
  logic [BW-1:0]            res_hi;
  logic [$clog2(DEPTH+1)-1:0] res_count;
  logic                     busy;

  int          testCount = 0;
  int          failCount = 0;
  logic [63:0] expQ [$];
  logic [63:0] monExp;
  logic [31:0] edgeModel [6];
  int          ipModel;

  edgcol_dispatch #(
    .BUS_WIDTH (BW),
    .NUM_HB    (NHB),
    .RES_DEPTH (DEPTH),
    .IMM_WIDTH (IMMW)
  ) dut (
    .clk          (clk),
    .rstb         (rstb),
    .edge_wr_ena  (edge_wr_ena),
    .edge_wr_addr (edge_wr_addr),
    .edge_wr_imm  (edge_wr_imm),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .hb_start     (hb_start),
    .hb_done      (hb_done),
    .hb_result    (hb_result),
    .hb_edge      (hb_edge),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_lo       (res_lo),
    .res_hi       (res_hi),
    .res_count    (res_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [191:0] actual,
                             input logic [191:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a pop happens at the next rising edge.
  always @(negedge clk) begin
    if (rstb && res_valid && res_ready) begin
      if (expQ.size() == 0) begin
        testCount++;
        failCount++;
        $display("[TB] FAIL res_unexpected: got %0h, expected no result", {res_hi, res_lo});
      end else begin
        monExp = expQ.pop_front();
        checkOutput("res_order", {res_hi, res_lo}, monExp);
      end
    end
  end

  // One stimulus cycle: optional edge write and/or command. A command
  // waits (bounded) for cmd_ready, then its operand snapshot is checked.
  task automatic applyStimulus(input bit wr, input logic [2:0] addr,
                               input logic [IMMW-1:0] imm, input bit cmd,
                               input logic [63:0] res, output int unitOut);
    logic [SNAPW-1:0] snapExp;
    int u;
    int waitCnt;
    unitOut = 0;
    if (cmd) begin
      waitCnt = 0;
      while (!cmd_ready && waitCnt < 20) begin
        cycle();
        waitCnt++;
      end
      if (!cmd_ready) begin
        testCount++;
        failCount++;
        $display("[TB] FAIL cmd_ready_timeout: got 0, expected 1");
        cmd = 1'b0;
      end
    end
    edge_wr_ena  = wr;
    edge_wr_addr = addr;
    edge_wr_imm  = imm;
    cmd_valid    = cmd;
    for (int e = 0; e < 6; e++) snapExp[e*32 +: 32] = edgeModel[e];
    u = ipModel;
    if (cmd) expQ.push_back(res);
    cycle();
    if (wr && addr < 3'd6) edgeModel[addr] = {imm, 6'b0};
    edge_wr_ena = 1'b0;
    cmd_valid   = 1'b0;
    if (cmd) begin
      checkOutput("hb_start_after_accept", hb_start[u], 1);
      checkOutput("snapshot", hb_edge[u*SNAPW +: SNAPW], snapExp);
      ipModel = (ipModel + 1) % NHB;
      unitOut = u;
    end
  endtask

  task automatic fireDone(input int unit, input logic [63:0] value);
    hb_done = '0;
    hb_done[unit] = 1'b1;
    hb_result[unit*64 +: 64] = value;
    cycle();
    hb_done   = '0;
    hb_result = '0;
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    res_ready = 1'b1;
    while ((res_valid || expQ.size() != 0) && cnt < 40) begin
      cycle();
      cnt++;
    end
    if (cnt >= 40) begin
      testCount++;
      failCount++;
      $display("[TB] FAIL drain_timeout: got %0d pending, expected 0", expQ.size());
    end
    res_ready = 1'b0;
  endtask

  task automatic doReset();
    rstb        = 1'b0;
    edge_wr_ena = 1'b0;
    cmd_valid   = 1'b0;
    hb_done     = '0;
    hb_result   = '0;
    res_ready   = 1'b0;
    repeat (3) cycle();
    expQ.delete();
    ipModel = 0;
    for (int e = 0; e < 6; e++) edgeModel[e] = '0;
    rstb = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int u, u0, u1, ua, ub;
    edge_wr_addr = '0;
    edge_wr_imm  = '0;
    doReset();

    // Reset state
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_count", res_count, 0);
    checkOutput("rst_res_data", {res_hi, res_lo}, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_hb_start", hb_start, 0);
    checkOutput("rst_hb_edge", hb_edge, 0);

    // Edge writes, including an ignored index 6
    applyStimulus(1, 3'd0, 26'h1, 0, 0, u);
    applyStimulus(1, 3'd5, 26'h3FFFFFF, 0, 0, u);
    applyStimulus(1, 3'd6, 26'h155, 0, 0, u);

    // Two back-to-back commands; unit1 completes first
    applyStimulus(0, 0, 0, 1, 64'hA, u0);
    checkOutput("e0_value", hb_edge[u0*SNAPW +: 32], 32'h40);
    checkOutput("e5_value", hb_edge[u0*SNAPW + 160 +: 32], 32'hFFFFFFC0);
    checkOutput("e1to4_zero", hb_edge[u0*SNAPW + 32 +: 128], 0);
    checkOutput("b2b_ready", cmd_ready, 1);
    applyStimulus(0, 0, 0, 1, 64'hB, u1);
    checkOutput("b2b_units", {u0[1:0], u1[1:0]}, 4'b0001);
    fireDone(u1, 64'hB);
    cycle();
    checkOutput("no_out_of_order_push", res_valid, 0);
    fireDone(u0, 64'hA);
    checkOutput("push_latency_d1", res_valid, 0);
    cycle();
    checkOutput("push_latency_d2", res_valid, 1);
    checkOutput("head_lo_a", res_lo, 32'hA);
    drain();

    // Low/high split
    applyStimulus(0, 0, 0, 1, 64'h1234_5678_9ABC_DEF0, u);
    fireDone(u, 64'h1234_5678_9ABC_DEF0);
    repeat (2) cycle();
    checkOutput("split_lo", res_lo, 32'h9ABCDEF0);
    checkOutput("split_hi", res_hi, 32'h12345678);
    drain();

    // Edge write to e2 in the accept cycle
    applyStimulus(1, 3'd2, 26'h777, 1, 64'h33, ua);
    checkOutput("e2_old_in_snapshot", hb_edge[ua*SNAPW + 64 +: 32], 32'h0);
    applyStimulus(0, 0, 0, 1, 64'h44, ub);
    checkOutput("e2_new_in_snapshot", hb_edge[ub*SNAPW + 64 +: 32], 32'h1DDC0);
    fireDone(ua, 64'h33);
    fireDone(ub, 64'h44);
    drain();

    // Six results into a four-entry buffer with no pops
    res_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 0, 1, 64'h100 + 64'(k), u);
      fireDone(u, 64'h100 + 64'(k));
    end
    repeat (2) cycle();
    checkOutput("full_count", res_count, 4);
    checkOutput("full_cmd_ready", cmd_ready, 0);
    checkOutput("full_units_stalled", hb_start, 0);
    checkOutput("full_busy", busy, 1);
    checkOutput("full_head", {res_hi, res_lo}, 64'h100);
    // Pop and retire together while full
    res_ready = 1'b1;
    cycle();
    checkOutput("full_pop_retire_count", res_count, 4);
    drain();
    checkOutput("drained_count", res_count, 0);
    checkOutput("drained_cmd_ready", cmd_ready, 1);
    checkOutput("drained_busy", busy, 0);

    // Reset while two units run, then late hb_done pulses
    applyStimulus(0, 0, 0, 1, 64'h55, ua);
    applyStimulus(0, 0, 0, 1, 64'h66, ub);
    checkOutput("both_running", hb_start, 2'b11);
    doReset();
    fireDone(0, 64'h55);
    fireDone(1, 64'h66);
    res_ready = 1'b1;
    repeat (3) cycle();
    checkOutput("post_rst_res_valid", res_valid, 0);
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_cmd_ready", cmd_ready, 1);
    checkOutput("post_rst_count", res_count, 0);
    res_ready = 1'b0;

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
